inst_encoder: RTL

- Inverse of the RV32 instruction decoder: takes field-level instruction requests (type, opcode, registers, funct3/funct7, immediate) and assembles 32-bit RV32I instruction words.
- Results leave through a small FIFO as (address, instruction) write beats for the instruction-memory loader and self-test program builder.
- Out-of-range or misaligned immediates are flagged, and a NOP is emitted in their place.

---
 rtl/rv32_pkg.sv | 82 ++++++++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/inst_encoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv32_pkg
// Brief  : Shared RV32I definitions: instruction format enum, opcode
//          constants, canonical NOP and the field-to-word encode function.
// Rev    : 1.0  initial release
// ============================================================================
package rv32_pkg;

    typedef enum logic [2:0] {
        INST_R  = 3'd0,
        INST_I  = 3'd1,
        INST_S  = 3'd2,
        INST_SB = 3'd3,
        INST_UJ = 3'd4,
        INST_U  = 3'd5
    } inst_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } enc_t;

    // Assemble one instruction word; any illegal immediate or unknown
    // format yields the NOP with err set so the slot is still consumed.
    function automatic enc_t encode(
        input logic [2:0]  typ,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        enc_t               r;
        logic signed [31:0] s;
        s      = imm;
        r.inst = NOP_INST;
        r.err  = 1'b0;
        case (typ)
            INST_R:  r.inst = {funct7, rs2, rs1, funct3, rd, opcode};
            INST_I: begin
                if (s < -32'sd2048 || s > 32'sd2047) r.err = 1'b1;
                else r.inst = {imm[11:0], rs1, funct3, rd, opcode};
            end
            INST_S: begin
                if (s < -32'sd2048 || s > 32'sd2047) r.err = 1'b1;
                else r.inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            INST_SB: begin
                if (s < -32'sd4096 || s > 32'sd4094 || imm[0]) r.err = 1'b1;
                else r.inst = {imm[12], imm[10:5], rs2, rs1, funct3,
                               imm[4:1], imm[11], opcode};
            end
            INST_UJ: begin
                if (s < -32'sd1048576 || s > 32'sd1048574 || imm[0]) r.err = 1'b1;
                else r.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
            INST_U: begin
                if (imm[11:0] != 12'd0) r.err = 1'b1;
                else r.inst = {imm[31:12], rd, opcode};
            end
            default: r.err = 1'b1;
        endcase
        if (r.err) r.inst = NOP_INST;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with show-ahead head output. Push while full
//          is dropped even if a pop happens in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] c_ptr_one = 1;
    localparam logic [AW:0]   c_cnt_one = 1;
    localparam logic [AW:0]   c_depth   = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == c_depth);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage array; no reset needed, validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module : inst_encoder
// Brief  : Field-level request to RV32I word assembler. Encoded words are
//          tagged with a sequential word address and queued as write beats.
// Rev    : 1.0  initial release
// ============================================================================
module inst_encoder
    import rv32_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count,
    output logic              busy,
    output logic              done
);
    localparam int              c_width = 32 + ADDR_W + 1;
    localparam int              c_cw    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_addr_one = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    r_addr;
    logic [7:0]           r_err_count;
    logic                 w_load_addr;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_cw-1:0]      w_count;
    logic [c_width-1:0]   w_din;
    logic [c_width-1:0]   w_dout;
    enc_t                 w_enc;

    assign w_enc = encode(in_type, in_opcode, in_rd, in_rs1, in_rs2,
                          in_funct3, in_funct7, in_imm);

    assign in_ready    = (r_state == ST_RUN) && !w_full;
    assign w_accept    = in_valid && in_ready;
    assign w_pop       = out_ready && !w_empty;
    assign w_din       = {w_enc.inst, r_addr, w_enc.err};
    assign w_load_addr = start && ((r_state == ST_IDLE) ||
                                   (r_state == ST_RUN && !stop));

    // Head fields are forced to zero while empty so stale RAM never shows.
    assign out_valid = !w_empty;
    assign out_inst  = w_empty ? 32'd0 : w_dout[c_width-1 -: 32];
    assign out_addr  = w_empty ? '0    : w_dout[ADDR_W:1];
    assign out_err   = !w_empty && w_dout[0];
    assign err_count = r_err_count;
    assign busy      = (r_state != ST_IDLE);

    sync_fifo #(
        .WIDTH (c_width),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and done pulse; drain ends on the edge of the final pop.
    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            ST_RUN:   if (stop)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (w_empty || (w_count == c_cw'(1) && w_pop)) begin
                    w_state_nxt = ST_IDLE;
                    done        = 1'b1;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Write address: reloaded on start, advanced by every accepted request.
    always_ff @(posedge clk) begin
        if (rst)              r_addr <= c_base;
        else if (w_load_addr) r_addr <= c_base;
        else if (w_accept)    r_addr <= r_addr + c_addr_one;
    end

    // Saturating count of requests that were replaced by a NOP.
    always_ff @(posedge clk) begin
        if (rst)
            r_err_count <= 8'd0;
        else if (w_accept && w_enc.err && r_err_count != 8'hFF)
            r_err_count <= r_err_count + 8'd1;
    end

endmodule
`default_nettype wire
